// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter (dmem_arbiter).
package dmem_arb_pkg;

    localparam int DEF_AW           = 32;
    localparam int DEF_DW           = 32;
    localparam int DEF_STARVE_LIMIT = 8;

    // Arbiter FSM states
    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Owner of the read response due in the next cycle
    typedef enum logic [1:0] {
        NONE  = 2'd0,
        OWN_C = 2'd1,
        OWN_D = 2'd2
    } owner_t;

    // Bits needed to hold a count of 0..limit
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating aging counter for the D port: counts consecutive denied
// D-request cycles and flags when the limit is reached.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int LIMIT = DEF_STARVE_LIMIT,
    parameter int CW    = cnt_width(LIMIT)
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [CW-1:0] LIMIT_V = CW'(LIMIT);

    logic [CW-1:0] cnt_q;

    // Clear has priority; increment holds once the limit is reached
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != LIMIT_V)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign at_limit = (cnt_q == LIMIT_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data_memory between the core port (C)
// and the DMA/debug loader port (D). C has fixed priority, an aging counter
// guarantees D progress, and D may lock the memory for atomic sequences.
// Optional grant/starvation statistics are built when DMEM_ARB_STATS_EN
// is defined.
//
// state | meaning
// ------+-----------------------------------------------------------
// ARB   | normal arbitration, C priority unless D has aged out
// LOCK  | D owns the memory exclusively until it drops d_lock
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic          d_lock,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_rd_en,
    output logic          m_wr_en,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wr_dat,
    input  logic [DW-1:0] m_rd_dat,
    output logic          locked
`ifdef DMEM_ARB_STATS_EN
   ,output logic [31:0]   c_gnt_cnt,
    output logic [31:0]   d_gnt_cnt,
    output logic [31:0]   starve_evt_cnt
`endif
);

    arb_state_t state_q, state_d;
    owner_t     rsp_owner_q;
    logic       at_limit;
    logic       forced_d;
    logic       starve_inc, starve_clr;

    dmem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (clk),
        .reset    (reset),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .at_limit (at_limit)
    );

    assign starve_inc = d_req & ~d_gnt;
    assign starve_clr = d_gnt | ~d_req;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant decision and next state; grants are held low while in reset
    // so every output is zero as soon as reset asserts
    always_comb begin
        state_d  = state_q;
        c_gnt    = 1'b0;
        d_gnt    = 1'b0;
        forced_d = 1'b0;
        case (state_q)
            ARB: begin
                d_gnt    = d_req & (~c_req | at_limit);
                c_gnt    = c_req & ~d_gnt;
                forced_d = d_gnt & c_req;
                if (d_gnt && d_lock) begin
                    state_d = LOCK;
                end
            end
            LOCK: begin
                d_gnt = d_req;
                if (!d_lock) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
        if (!reset) begin
            c_gnt    = 1'b0;
            d_gnt    = 1'b0;
            forced_d = 1'b0;
        end
    end

    assign locked = (state_q == LOCK);

    // Memory command mux: idle bus is driven to zero
    always_comb begin
        m_rd_en  = 1'b0;
        m_wr_en  = 1'b0;
        m_addr   = '0;
        m_wr_dat = '0;
        if (c_gnt) begin
            m_rd_en  = ~c_we;
            m_wr_en  = c_we;
            m_addr   = c_addr;
            m_wr_dat = c_wdata;
        end else if (d_gnt) begin
            m_rd_en  = ~d_we;
            m_wr_en  = d_we;
            m_addr   = d_addr;
            m_wr_dat = d_wdata;
        end
    end

    // Remember who issued the read so next cycle's data goes to that port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_owner_q <= NONE;
        end else if (c_gnt && !c_we) begin
            rsp_owner_q <= OWN_C;
        end else if (d_gnt && !d_we) begin
            rsp_owner_q <= OWN_D;
        end else begin
            rsp_owner_q <= NONE;
        end
    end

    assign c_rvalid = (rsp_owner_q == OWN_C);
    assign d_rvalid = (rsp_owner_q == OWN_D);
    assign c_rdata  = c_rvalid ? m_rd_dat : '0;
    assign d_rdata  = d_rvalid ? m_rd_dat : '0;

`ifdef DMEM_ARB_STATS_EN
    // Grant and forced-D counters, wrapping modulo 2^32
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_gnt_cnt      <= '0;
            d_gnt_cnt      <= '0;
            starve_evt_cnt <= '0;
        end else begin
            if (c_gnt)    c_gnt_cnt      <= c_gnt_cnt + 32'd1;
            if (d_gnt)    d_gnt_cnt      <= d_gnt_cnt + 32'd1;
            if (forced_d) starve_evt_cnt <= starve_evt_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a small behavioural data_memory.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        c_req, c_we;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic        c_gnt, c_rvalid;
    logic        d_req, d_we, d_lock;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        d_gnt, d_rvalid;
    logic        m_rd_en, m_wr_en;
    logic [31:0] m_addr, m_wr_dat, m_rd_dat;
    logic        locked;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] c_gnt_cnt, d_gnt_cnt, starve_evt_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:255];

    dmem_arbiter #(
        .AW           (32),
        .DW           (32),
        .STARVE_LIMIT (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .c_req    (c_req),
        .c_we     (c_we),
        .c_addr   (c_addr),
        .c_wdata  (c_wdata),
        .c_gnt    (c_gnt),
        .c_rvalid (c_rvalid),
        .c_rdata  (c_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_lock   (d_lock),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_rd_en  (m_rd_en),
        .m_wr_en  (m_wr_en),
        .m_addr   (m_addr),
        .m_wr_dat (m_wr_dat),
        .m_rd_dat (m_rd_dat),
        .locked   (locked)
`ifdef DMEM_ARB_STATS_EN
       ,.c_gnt_cnt      (c_gnt_cnt),
        .d_gnt_cnt      (d_gnt_cnt),
        .starve_evt_cnt (starve_evt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data_memory stand-in: preloaded while in reset, read data one cycle later
    always @(posedge clk) begin
        if (!reset) begin
            mem[8'h04] <= 32'h4444_4444;
            mem[8'h08] <= 32'h8888_8888;
            mem[8'h0C] <= 32'hCCCC_CCCC;
            mem[8'h10] <= 32'hDEAD_BEEF;
        end else if (m_wr_en) begin
            mem[m_addr[7:0]] <= m_wr_dat;
        end
        if (m_rd_en) m_rd_dat <= mem[m_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int c_tot, d_tot, run, max_run;

    initial begin
        reset = 1'b0;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_lock = 0;

        // Reset state
        repeat (3) tick();
        #1;
        check("rst_c_gnt",    c_gnt,    0);
        check("rst_d_gnt",    d_gnt,    0);
        check("rst_m_rd_en",  m_rd_en,  0);
        check("rst_m_wr_en",  m_wr_en,  0);
        check("rst_m_addr",   m_addr,   0);
        check("rst_c_rvalid", c_rvalid, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        check("rst_locked",   locked,   0);

        // 1: core read of 0x10
        tick();
        reset = 1'b1;
        c_req = 1; c_we = 0; c_addr = 32'h10;
        #1;
        check("s1_c_gnt",   c_gnt,   1);
        check("s1_d_gnt",   d_gnt,   0);
        check("s1_m_rd_en", m_rd_en, 1);
        check("s1_m_wr_en", m_wr_en, 0);
        check("s1_m_addr",  m_addr,  32'h10);
        tick();
        c_req = 0;
        #1;
        check("s1_c_rvalid", c_rvalid, 1);
        check("s1_c_rdata",  c_rdata,  32'hDEAD_BEEF);
        check("s1_d_rvalid", d_rvalid, 0);
        check("s1_d_rdata",  d_rdata,  0);
        check("s1_m_rd_idle", m_rd_en, 0);

        // 2: both ports request every cycle for 90 cycles after a fresh reset
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        c_req = 1; c_we = 0; c_addr = 32'h04;
        d_req = 1; d_we = 0; d_addr = 32'h08; d_lock = 0;
        c_tot = 0; d_tot = 0; run = 0; max_run = 0;
        for (int i = 0; i < 90; i++) begin
            #1;
            check("s2_d_gnt", d_gnt, (i % 9) == 8);
            check("s2_c_gnt", c_gnt, (i % 9) != 8);
            if (c_gnt) c_tot++;
            if (d_gnt) begin
                d_tot++;
                run = 0;
            end else begin
                run++;
                if (run > max_run) max_run = run;
            end
            tick();
        end
        c_req = 0; d_req = 0;
        #1;
        check("s2_c_total",    c_tot,   80);
        check("s2_d_total",    d_tot,   10);
        check("s2_max_denied", max_run, 8);
`ifdef DMEM_ARB_STATS_EN
        check("s6_c_gnt_cnt",      c_gnt_cnt,      80);
        check("s6_d_gnt_cnt",      d_gnt_cnt,      10);
        check("s6_starve_evt_cnt", starve_evt_cnt, 10);
`endif

        // 3: locked D write, core write stalls until D releases
        tick();
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h55; d_lock = 1;
        #1;
        check("s3_d_gnt",    d_gnt,    1);
        check("s3_m_wr_en",  m_wr_en,  1);
        check("s3_m_addr",   m_addr,   32'h20);
        check("s3_m_wr_dat", m_wr_dat, 32'h55);
        check("s3_pre_lock", locked,   0);
        tick();
        d_req = 0;
        c_req = 1; c_we = 1; c_addr = 32'h30; c_wdata = 32'h77;
        #1;
        check("s3_locked_a",  locked,  1);
        check("s3_c_stall_a", c_gnt,   0);
        check("s3_bus_idle",  m_wr_en, 0);
        tick();
        #1;
        check("s3_locked_b",  locked, 1);
        check("s3_c_stall_b", c_gnt,  0);
        tick();
        d_lock = 0;
        #1;
        check("s3_locked_c",  locked, 1);
        check("s3_c_stall_c", c_gnt,  0);
        tick();
        #1;
        check("s3_unlocked",  locked,  0);
        check("s3_c_gnt",     c_gnt,   1);
        check("s3_c_wr_en",   m_wr_en, 1);
        check("s3_c_addr",    m_addr,  32'h30);
        tick();
        c_req = 0; c_we = 0;
        #1;
        check("s3_mem20", mem[8'h20], 32'h55);
        check("s3_mem30", mem[8'h30], 32'h77);

        // 4: back-to-back reads C@4, D@8, C@C
        tick();
        c_req = 1; c_we = 0; c_addr = 32'h04;
        #1;
        check("s4_c_gnt_1", c_gnt, 1);
        tick();
        c_req = 0;
        d_req = 1; d_we = 0; d_addr = 32'h08;
        #1;
        check("s4_d_gnt_2",    d_gnt,    1);
        check("s4_c_rvalid_2", c_rvalid, 1);
        check("s4_c_rdata_2",  c_rdata,  32'h4444_4444);
        check("s4_d_rvalid_2", d_rvalid, 0);
        tick();
        d_req = 0;
        c_req = 1; c_addr = 32'h0C;
        #1;
        check("s4_c_gnt_3",    c_gnt,    1);
        check("s4_d_rvalid_3", d_rvalid, 1);
        check("s4_d_rdata_3",  d_rdata,  32'h8888_8888);
        check("s4_c_rvalid_3", c_rvalid, 0);
        check("s4_c_rdata_3",  c_rdata,  0);
        tick();
        c_req = 0;
        #1;
        check("s4_c_rvalid_4", c_rvalid, 1);
        check("s4_c_rdata_4",  c_rdata,  32'hCCCC_CCCC);
        check("s4_d_rvalid_4", d_rvalid, 0);
        tick();
        #1;
        check("s4_c_rvalid_5", c_rvalid, 0);
        check("s4_d_rvalid_5", d_rvalid, 0);

        // 5: reset while locked with a D read outstanding
        tick();
        d_req = 1; d_we = 0; d_addr = 32'h08; d_lock = 1;
        #1;
        check("s5_d_gnt", d_gnt, 1);
        tick();
        c_req = 1; c_we = 0; c_addr = 32'h10;
        #1;
        check("s5_locked",      locked,   1);
        check("s5_rvalid_pend", d_rvalid, 1);
        reset = 1'b0;
        #1;
        check("s5_rst_d_rvalid", d_rvalid, 0);
        check("s5_rst_d_rdata",  d_rdata,  0);
        check("s5_rst_locked",   locked,   0);
        check("s5_rst_d_gnt",    d_gnt,    0);
        check("s5_rst_c_gnt",    c_gnt,    0);
        check("s5_rst_m_rd_en",  m_rd_en,  0);
        check("s5_rst_m_addr",   m_addr,   0);
        tick();
        reset = 1'b1;
        d_req = 0; d_lock = 0;
        #1;
        check("s5_post_c_gnt",  c_gnt,   1);
        check("s5_post_m_rd",   m_rd_en, 1);
        check("s5_post_locked", locked,  0);
        tick();
        c_req = 0;
        #1;
        check("s5_post_c_rvalid", c_rvalid, 1);
        check("s5_post_c_rdata",  c_rdata,  32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
